// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller: one full-adder cell is time-shared
// across all operand bits, LSB first, with a registered {cout, sum_out} result.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  // Half-adder cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder built from two half adders and an OR: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic [1:0] ha1;
    logic [1:0] ha2;
    ha1 = half_add(x, y);
    ha2 = half_add(ha1[0], c);
    return {ha1[1] | ha2[1], ha2[0]};
  endfunction

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       fa_s;

  assign fa_s = full_add(a_sh_q[0], b_sh_q[0], carry_q);

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, one bit per RUN cycle, result load on the last bit.
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
          s_sh_d  = '0;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      S_RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_s[1];
        s_sh_d  = {fa_s[0], s_sh_q[WIDTH-1:1]};
        // Counter wraps to zero on the final bit so it never passes WIDTH-1.
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          sum_d  = {fa_s[0], s_sh_q[WIDTH-1:1]};
          cout_d = fa_s[1];
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Status outputs are registered from the next state so they align with state_q.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_RUN:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed scenarios plus random
// operations compared against a plain a+b+cin reference.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;
  localparam int CNTW  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_cout;

  serial_adder_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c);
    return ({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c});
  endfunction

  // Issues one op from an idle negedge; observes until one cycle past done (bounded).
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                        output int lat, output int busy_n, output int done_n,
                        output logic [WIDTH-1:0] s, output logic co, output logic stable);
    lat = -1; busy_n = 0; done_n = 0; s = '0; co = 1'b0; stable = 1'b1;
    a_in = a; b_in = b; cin = c; start = 1'b1;
    for (int k = 1; k <= WIDTH + 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin = 1'($urandom);
      if (busy === 1'b1) begin
        busy_n++;
        if (sum_out !== prev_sum || cout !== prev_cout) stable = 1'b0;
      end
      if (done === 1'b1) begin
        done_n++;
        if (lat < 0) begin lat = k; s = sum_out; co = cout; end
      end
      if (lat > 0 && k >= lat + 1) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    #3;
    checks++;
    if ({busy, done, cout, sum_out} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b cout=%b sum=%h, want 0 0 0 00", busy, done, cout, sum_out);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bn, dn; logic [WIDTH-1:0] s; logic co, st; logic [WIDTH:0] exp;
    exp = ref_add(8'h5A, 8'h3C, 1'b0);
    run_op(8'h5A, 8'h3C, 1'b0, lat, bn, dn, s, co, st);
    checks++;
    if (lat !== WIDTH + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, WIDTH + 1); end
    checks++;
    if (bn !== WIDTH) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", bn, WIDTH); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", dn); end
    checks++;
    if ({co, s} !== exp || exp !== 9'h096) begin
      errors++; $display("FAIL basic_result: got %b_%h want 0_96", co, s);
    end
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL basic_hold: result changed during RUN, got %b want 1", st); end
    prev_sum = exp[WIDTH-1:0]; prev_cout = exp[WIDTH];
  endtask

  task automatic test_carry;
    int lat, bn, dn; logic [WIDTH-1:0] s; logic co, st;
    run_op(8'hFF, 8'h01, 1'b0, lat, bn, dn, s, co, st);
    checks++;
    if ({co, s} !== 9'h100) begin errors++; $display("FAIL carry_ff_01: got %b_%h want 1_00", co, s); end
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL carry_hold: got %b want 1", st); end
    prev_sum = 8'h00; prev_cout = 1'b1;
    run_op(8'hFF, 8'hFF, 1'b1, lat, bn, dn, s, co, st);
    checks++;
    if ({co, s} !== 9'h1FF) begin errors++; $display("FAIL carry_ff_ff_1: got %b_%h want 1_ff", co, s); end
    prev_sum = 8'hFF; prev_cout = 1'b1;
  endtask

  task automatic test_ignore_start;
    int dn; logic [WIDTH-1:0] s; logic co;
    dn = 0; s = '0; co = 1'b0;
    a_in = 8'h20; b_in = 8'h03; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 3 || k == 4) begin start = 1'b1; a_in = 8'h11; b_in = 8'h11; cin = 1'b1; end
      if (done === 1'b1) begin dn++; s = sum_out; co = cout; end
    end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL ignore_done_pulses: got %0d want 1", dn); end
    checks++;
    if ({co, s} !== 9'h023) begin errors++; $display("FAIL ignore_result: got %b_%h want 0_23", co, s); end
    prev_sum = 8'h23; prev_cout = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int dn, lat, bn; logic [WIDTH-1:0] s; logic co, st;
    a_in = 8'h80; b_in = 8'h80; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum_out} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b cout=%b sum=%h, want 0 0 0 00", busy, done, cout, sum_out);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d pulses want 0", dn); end
    run_op(8'h01, 8'h01, 1'b0, lat, bn, dn, s, co, st);
    checks++;
    if ({co, s} !== 9'h002) begin errors++; $display("FAIL midrun_next_op: got %b_%h want 0_02", co, s); end
    prev_sum = 8'h02; prev_cout = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [WIDTH:0] ops_res [0:29];
    int done_at [$];
    logic [WIDTH:0] got [$];
    logic [WIDTH-1:0] ra, rb; logic rc;
    for (int k = 0; k <= 29; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (done === 1'b1) begin done_at.push_back(k); got.push_back({cout, sum_out}); end
      end
      if (k < 29) begin
        ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
        a_in = ra; b_in = rb; cin = rc; start = 1'b1;
        ops_res[k] = ref_add(ra, rb, rc);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (done_at.size() !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d done pulses want 3", done_at.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (done_at[i] !== 9 + 10 * i) begin
          errors++; $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d", i, done_at[i], 9 + 10 * i);
        end
        checks++;
        if (got[i] !== ops_res[10 * i]) begin
          errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, got[i], ops_res[10 * i]);
        end
      end
      prev_sum = ops_res[20][WIDTH-1:0]; prev_cout = ops_res[20][WIDTH];
    end
  endtask

  task automatic test_random;
    int lat, bn, dn; logic [WIDTH-1:0] s, ra, rb; logic co, st, rc; logic [WIDTH:0] exp;
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
      exp = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, lat, bn, dn, s, co, st);
      checks++;
      if ({co, s} !== exp || lat !== WIDTH + 1) begin
        errors++;
        $display("FAIL random[%0d]: %h+%h+%b got %b_%h lat %0d want %h lat %0d",
                 n, ra, rb, rc, co, s, lat, exp, WIDTH + 1);
      end
      checks++;
      if (st !== 1'b1 || dn !== 1) begin
        errors++; $display("FAIL random_hold[%0d]: stable=%b pulses=%0d want 1 1", n, st, dn);
      end
      prev_sum = exp[WIDTH-1:0]; prev_cout = exp[WIDTH];
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
